// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg -- shared types and default parameter values for the mux_scan
// channel multiplexer / scanner.
//
// Contents:
//   state_t        : controller states (IDLE, MANUAL, SCAN)
//   NCH_DEFAULT    : default number of input channels
//   W_DEFAULT      : default data width per channel
//   DWELL_DEFAULT  : default cycles spent on each channel while scanning
//
// Optional feature macro used by the importing files: MUX_SCAN_MASK_EN.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int NCH_DEFAULT   = 4;
    localparam int W_DEFAULT     = 1;
    localparam int DWELL_DEFAULT = 4;

endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next -- combinational next-channel finder for the scanner.
//
// Given a base channel index, returns the next channel after it in ascending
// order, modulo NCH, together with a flag saying the step passed index NCH-1.
//
// Ports:
//   base : channel index to advance from
//   mask : (MUX_SCAN_MASK_EN only) 1 = channel skipped
//   nxt  : next channel index
//   wrap : the step went past NCH-1 back towards 0
//   none : every channel is masked (nxt is meaningless); always 0 without the mask
//
// Configuration macro: MUX_SCAN_MASK_EN. Without it the block is a plain
// increment-modulo-NCH.
module mux_scan_next
    import mux_scan_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int SW  = $clog2(NCH)
) (
    input  logic [SW-1:0]  base,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NCH-1:0] mask,
`endif
    output logic [SW-1:0]  nxt,
    output logic           wrap,
    output logic           none
);

`ifdef MUX_SCAN_MASK_EN
    int sum;
    int idx;

    // Candidates are base+1 .. base+NCH; the last candidate is base itself,
    // so a single unmasked channel keeps being re-selected (and wraps).
    always_comb begin
        nxt  = '0;
        wrap = 1'b0;
        none = 1'b1;
        sum  = 0;
        idx  = 0;
        for (int off = 1; off <= NCH; off++) begin
            if (none) begin
                sum = int'(base) + off;
                idx = (sum >= NCH) ? (sum - NCH) : sum;
                if (!mask[idx[SW-1:0]]) begin
                    nxt  = idx[SW-1:0];
                    wrap = (sum >= NCH);
                    none = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        none = 1'b0;
        wrap = (base == SW'(NCH - 1));
        nxt  = wrap ? '0 : base + 1'b1;
    end
`endif

endmodule

// File: rtl/mux_scan.sv
// mux_scan -- registered N-channel multiplexer with manual select and an
// automatic round-robin scan mode with a programmable dwell time.
//
// Parameters:
//   NCH   : number of channels (2..16)
//   W     : data width per channel (1..32)
//   DWELL : cycles spent on each channel while scanning (1..255)
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : block enable (0 forces IDLE)
//   mode  : 0 = manual select, 1 = auto-scan
//   sel   : manual channel select
//   d     : channel data, channel k at d[k*W +: W]
//   mask  : (MUX_SCAN_MASK_EN only) 1 = channel skipped while scanning
//   y     : registered selected data
//   valid : y holds a legal channel sample
//   ch    : channel index that produced y
//   wrap  : one-cycle pulse on the cycle the scan returns to its first channel
//
// Configuration macro: MUX_SCAN_MASK_EN adds the mask port; without it every
// channel is scanned.
//
// Timing: the state transition and the output load happen on the same edge,
// so the edge that enters SCAN already presents the first scan channel and
// counts as its first dwell cycle.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int NCH   = NCH_DEFAULT,
    parameter  int W     = W_DEFAULT,
    parameter  int DWELL = DWELL_DEFAULT,
    localparam int SW    = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH*W-1:0] d,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NCH-1:0]   mask,
`endif
    output logic [W-1:0]     y,
    output logic             valid,
    output logic [SW-1:0]    ch,
    output logic             wrap
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t        state;
    logic [SW-1:0] scan_ch;
    logic [7:0]    dwell_cnt;
    logic          wrap_pend;
    logic          seek;

    logic [W-1:0]  man_y;
    logic          man_ok;
    logic          restart;
    logic [SW-1:0] first_ch;
    logic [SW-1:0] cur_ch;
    logic [7:0]    cur_dwell;
    logic [W-1:0]  scan_y;
    logic [SW-1:0] adv_ch;
    logic          adv_wrap;
    logic          none_all;
    logic          first_wrap_unused;
    logic          adv_none_unused;

    // Out-of-range indices (only possible for non-power-of-2 NCH) give zero.
    function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] dv,
                                          input logic [SW-1:0]    idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SW'(k)) r = dv[k*W +: W];
        end
        return r;
    endfunction

    assign man_y  = pick(d, sel);
    assign man_ok = ({1'b0, sel} < (SW + 1)'(NCH));

    // A scan (re)starts from its first channel whenever we were not already
    // scanning, or the previous cycle found every channel masked.
    assign restart   = (state != SCAN) || seek;
    assign cur_ch    = restart ? first_ch : scan_ch;
    assign cur_dwell = restart ? 8'd0 : dwell_cnt;
    assign scan_y    = pick(d, cur_ch);

    // First channel of a pass: the first eligible index searching up from 0.
    mux_scan_next #(
        .NCH (NCH),
        .SW  (SW)
    ) u_first (
        .base (SW'(NCH - 1)),
`ifdef MUX_SCAN_MASK_EN
        .mask (mask),
`endif
        .nxt  (first_ch),
        .wrap (first_wrap_unused),
        .none (none_all)
    );

    // Channel to move to when the current dwell expires.
    mux_scan_next #(
        .NCH (NCH),
        .SW  (SW)
    ) u_adv (
        .base (cur_ch),
`ifdef MUX_SCAN_MASK_EN
        .mask (mask),
`endif
        .nxt  (adv_ch),
        .wrap (adv_wrap),
        .none (adv_none_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            valid     <= 1'b0;
            ch        <= '0;
            wrap      <= 1'b0;
            scan_ch   <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            seek      <= 1'b0;
        end else if (!en) begin
            // IDLE: hold y/ch, drop the scan position.
            state     <= IDLE;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            scan_ch   <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            seek      <= 1'b0;
        end else if (!mode) begin
            state     <= MANUAL;
            y         <= man_y;
            ch        <= sel;
            valid     <= man_ok;
            wrap      <= 1'b0;
            scan_ch   <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            seek      <= 1'b0;
        end else begin
            state <= SCAN;
            if (none_all) begin
                // Nothing to scan: hold y/ch and re-seek once a channel frees up.
                valid     <= 1'b0;
                wrap      <= 1'b0;
                scan_ch   <= '0;
                dwell_cnt <= '0;
                wrap_pend <= 1'b0;
                seek      <= 1'b1;
            end else begin
                y     <= scan_y;
                ch    <= cur_ch;
                valid <= 1'b1;
                // The wrap detected at the advance is shown with the channel it
                // lands on, one edge later; a fresh pass never reports a wrap.
                wrap  <= restart ? 1'b0 : wrap_pend;
                seek  <= 1'b0;
                if (cur_dwell == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    scan_ch   <= adv_ch;
                    wrap_pend <= adv_wrap;
                end else begin
                    dwell_cnt <= cur_dwell + 8'd1;
                    scan_ch   <= cur_ch;
                    wrap_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan -- scoreboard bench for mux_scan.
//
// dut0: NCH=4, W=8, DWELL=3 (reset, manual, scan, mode switch, disable)
// dut1: NCH=4, W=8, DWELL=1 (advance every cycle; mask when MUX_SCAN_MASK_EN)
// dut2: NCH=3, W=8, DWELL=2 (non-power-of-2 channel count)
`timescale 1ns/1ps
module tb_mux_scan;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] ch;
        logic       valid;
        logic       wrap;
    } exp_t;

    localparam logic [31:0] D0 = 32'hD3C2B1A0;
    localparam logic [31:0] D1 = 32'h44332211;
    localparam logic [23:0] D2 = 24'h332211;

    logic clk;
    logic rst_n;

    logic        en0, mode0, valid0, wrap0;
    logic [1:0]  sel0, ch0;
    logic [31:0] d0;
    logic [7:0]  y0;

    logic        en1, mode1, valid1, wrap1;
    logic [1:0]  sel1, ch1;
    logic [31:0] d1;
    logic [7:0]  y1;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0]  mask1;
`endif

    logic        en2, mode2, valid2, wrap2;
    logic [1:0]  sel2, ch2;
    logic [23:0] d2;
    logic [7:0]  y2;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int total = 0;
    int bad   = 0;

    mux_scan #(.NCH(4), .W(8), .DWELL(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .sel(sel0), .d(d0),
        .y(y0), .valid(valid0), .ch(ch0), .wrap(wrap0)
    );

    mux_scan #(.NCH(4), .W(8), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel(sel1), .d(d1),
`ifdef MUX_SCAN_MASK_EN
        .mask(mask1),
`endif
        .y(y1), .valid(valid1), .ch(ch1), .wrap(wrap1)
    );

    mux_scan #(.NCH(3), .W(8), .DWELL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2), .d(d2),
        .y(y2), .valid(valid2), .ch(ch2), .wrap(wrap2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t ex(input logic [7:0] ey, input logic [1:0] ec,
                                input logic ev, input logic ew);
        exp_t r;
        r.y = ey; r.ch = ec; r.valid = ev; r.wrap = ew;
        return r;
    endfunction

    // Channel bytes of D0: A0, B1, C2, D3.
    function automatic logic [7:0] b0(input int c);
        return 8'hA0 + 8'(c) * 8'h11;
    endfunction

    // Channel bytes of D1 / D2: 11, 22, 33, 44.
    function automatic logic [7:0] b1(input int c);
        return 8'h11 * 8'(c + 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        en0 = 1'b1; mode0 = 1'b1; sel0 = 2'd0; d0 = D0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb0.push_back(ex(8'h00, 2'd0, 1'b0, 1'b0));
            if (i == 0) #2;
            else cyc();
            e = sb0.pop_front();
            total++;
            if ({y0, ch0, valid0, wrap0} !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y0, ch0, valid0, wrap0, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

    task automatic test_manual();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin rst_n = 1'b1; mode0 = 1'b0; sel0 = 2'd2; d0 = D0;
                         sb0.push_back(ex(8'hC2, 2'd2, 1'b1, 1'b0)); end
                1: begin sel0 = 2'd0; sb0.push_back(ex(8'hA0, 2'd0, 1'b1, 1'b0)); end
                2: begin sel0 = 2'd3; sb0.push_back(ex(8'hD3, 2'd3, 1'b1, 1'b0)); end
                3: begin d0 = 32'h5AC2B1A0; sb0.push_back(ex(8'h5A, 2'd3, 1'b1, 1'b0)); end
                default: begin sel0 = 2'd1; d0 = D0; sb0.push_back(ex(8'hB1, 2'd1, 1'b1, 1'b0)); end
            endcase
            cyc();
            e = sb0.pop_front();
            total++;
            if ({y0, ch0, valid0, wrap0} !== e) begin
                bad++;
                $display("FAIL manual[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y0, ch0, valid0, wrap0, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int   c;
        mode0 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            c = (i < 12) ? i / 3 : 0;
            sb0.push_back(ex(b0(c), 2'(c), 1'b1, (i == 12)));
            cyc();
            e = sb0.pop_front();
            total++;
            if ({y0, ch0, valid0, wrap0} !== e) begin
                bad++;
                $display("FAIL scan[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y0, ch0, valid0, wrap0, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

    task automatic test_mode_switch();
        exp_t e;
        int   c;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                en0 = 1'b0;
                sb0.push_back(ex(8'hA0, 2'd0, 1'b0, 1'b0));
            end else if (i <= 7) begin
                en0 = 1'b1; mode0 = 1'b1;
                c = (i - 1) / 3;
                sb0.push_back(ex(b0(c), 2'(c), 1'b1, 1'b0));
            end else if (i == 8) begin
                mode0 = 1'b0; sel0 = 2'd1;
                sb0.push_back(ex(8'hB1, 2'd1, 1'b1, 1'b0));
            end else begin
                mode0 = 1'b1;
                c = (i == 12) ? 1 : 0;
                sb0.push_back(ex(b0(c), 2'(c), 1'b1, 1'b0));
            end
            cyc();
            e = sb0.pop_front();
            total++;
            if ({y0, ch0, valid0, wrap0} !== e) begin
                bad++;
                $display("FAIL switch[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y0, ch0, valid0, wrap0, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

    task automatic test_disable();
        exp_t e;
        int   c;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                en0 = 1'b0;
                sb0.push_back(ex(8'hB1, 2'd1, 1'b0, 1'b0));
            end else begin
                en0 = 1'b1; mode0 = 1'b1;
                c = (i == 5) ? 1 : 0;
                sb0.push_back(ex(b0(c), 2'(c), 1'b1, 1'b0));
            end
            cyc();
            e = sb0.pop_front();
            total++;
            if ({y0, ch0, valid0, wrap0} !== e) begin
                bad++;
                $display("FAIL disable[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y0, ch0, valid0, wrap0, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

    task automatic test_nonpow2();
        exp_t e;
        int   j;
        int   c;
        d2 = D2;
        for (int i = 0; i < 11; i++) begin
            if (i == 0 || i == 2) begin
                en2 = 1'b1; mode2 = 1'b0; sel2 = 2'd3;
                sb2.push_back(ex(8'h00, 2'd3, 1'b0, 1'b0));
            end else if (i == 1) begin
                sel2 = 2'd2;
                sb2.push_back(ex(8'h33, 2'd2, 1'b1, 1'b0));
            end else begin
                mode2 = 1'b1;
                j = i - 3;
                c = (j / 2) % 3;
                sb2.push_back(ex(b1(c), 2'(c), 1'b1, (j == 6)));
            end
            cyc();
            e = sb2.pop_front();
            total++;
            if ({y2, ch2, valid2, wrap2} !== e) begin
                bad++;
                $display("FAIL nch3[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y2, ch2, valid2, wrap2, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_dwell1_mask();
        exp_t e;
        int   c;
        d1 = D1;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                en1 = 1'b1; mode1 = 1'b1; mask1 = 4'b0101;
                c = (i % 2 == 0) ? 1 : 3;
                sb1.push_back(ex(b1(c), 2'(c), 1'b1, (i == 2 || i == 4)));
            end else if (i < 7) begin
                mask1 = 4'b1111;
                sb1.push_back(ex(8'h22, 2'd1, 1'b0, 1'b0));
            end else if (i < 9) begin
                mask1 = 4'b0000;
                c = i - 7;
                sb1.push_back(ex(b1(c), 2'(c), 1'b1, 1'b0));
            end else begin
                mode1 = 1'b0; sel1 = 2'd0; mask1 = 4'b1111;
                sb1.push_back(ex(8'h11, 2'd0, 1'b1, 1'b0));
            end
            cyc();
            e = sb1.pop_front();
            total++;
            if ({y1, ch1, valid1, wrap1} !== e) begin
                bad++;
                $display("FAIL mask[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y1, ch1, valid1, wrap1, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask
`else
    task automatic test_dwell1_mask();
        exp_t e;
        int   c;
        d1 = D1;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                en1 = 1'b1; mode1 = 1'b1;
                c = i % 4;
                sb1.push_back(ex(b1(c), 2'(c), 1'b1, (i == 4 || i == 8)));
            end else begin
                mode1 = 1'b0; sel1 = 2'd2;
                sb1.push_back(ex(8'h33, 2'd2, 1'b1, 1'b0));
            end
            cyc();
            e = sb1.pop_front();
            total++;
            if ({y1, ch1, valid1, wrap1} !== e) begin
                bad++;
                $display("FAIL dwell1[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y1, ch1, valid1, wrap1, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask
`endif

    task automatic test_reset_midop();
        exp_t e;
        en0 = 1'b1; mode0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                rst_n = 1'b0;
                sb0.push_back(ex(8'h00, 2'd0, 1'b0, 1'b0));
                #2;
            end else if (i == 1) begin
                sb0.push_back(ex(8'h00, 2'd0, 1'b0, 1'b0));
                cyc();
            end else begin
                rst_n = 1'b1;
                sb0.push_back(ex(8'hA0, 2'd0, 1'b1, 1'b0));
                cyc();
            end
            e = sb0.pop_front();
            total++;
            if ({y0, ch0, valid0, wrap0} !== e) begin
                bad++;
                $display("FAIL midreset[%0d]: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         i, y0, ch0, valid0, wrap0, e.y, e.ch, e.valid, e.wrap);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en0 = 1'b0; mode0 = 1'b0; sel0 = 2'd0; d0 = D0;
        en1 = 1'b0; mode1 = 1'b0; sel1 = 2'd0; d1 = D1;
        en2 = 1'b0; mode2 = 1'b0; sel2 = 2'd0; d2 = D2;
`ifdef MUX_SCAN_MASK_EN
        mask1 = 4'b0000;
`endif
        test_reset();
        test_manual();
        test_scan();
        test_mode_switch();
        test_disable();
        test_nonpow2();
        test_dwell1_mask();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The block SHALL take parameter NCH, default 4, giving the number of input channels (2..16).
REQ-002 The block SHALL take parameter W, default 1, giving the data width per channel (1..32).
REQ-003 The block SHALL take parameter DWELL, default 4, giving the cycles per channel in scan mode (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: block enable.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects manual, 1 selects auto-scan.
REQ-008 The block SHALL have port sel, input, SW=$clog2(NCH) bits: manual channel select.
REQ-009 The block SHALL have port d, input, NCH*W bits: channel k occupies d[k*W +: W].
REQ-010 The block SHALL have port y, output, W bits: registered selected data.
REQ-011 The block SHALL have port valid, output, 1 bit: y holds a legal channel sample.
REQ-012 The block SHALL have port ch, output, SW bits: channel index that produced y.
REQ-013 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a scan pass completes.

Function
REQ-014 The FSM SHALL have three states: IDLE, MANUAL and SCAN; it is evaluated every rising clk edge.
REQ-015 Every state SHALL go to IDLE when en=0; IDLE SHALL go to MANUAL when en=1 and mode=0, and to SCAN when en=1 and mode=1; MANUAL<->SCAN SHALL follow mode.
REQ-016 In IDLE, y and ch SHALL hold their last values, valid SHALL be 0 and wrap SHALL be 0.
REQ-017 In MANUAL, each cycle SHALL load y<=d[sel], ch<=sel and valid<=1, giving a latency of 1 cycle from sel/d to y.
REQ-018 In MANUAL with sel>=NCH (non-power-of-2 NCH only), y SHALL load all zeros, ch SHALL load sel and valid SHALL be 0.
REQ-019 On entry to SCAN, the scan channel SHALL be 0 and the dwell counter SHALL be 0; y<=d[scan channel] each cycle with valid=1.
REQ-020 The dwell counter SHALL increment each SCAN cycle; when it reaches DWELL-1 it SHALL clear and the scan channel SHALL advance by 1.
REQ-021 Advancing from channel NCH-1 SHALL return the scan channel to 0 and assert wrap for exactly that one cycle.
REQ-022 When DWELL=1, the channel SHALL advance every cycle.
REQ-023 When mode changes mid-dwell, the new state SHALL take effect on the next edge; the scan position SHALL be discarded, and re-entry to SCAN SHALL restart at channel 0.
REQ-024 When en drops mid-scan, the scan position SHALL be discarded in the same way.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, y=0, valid=0, ch=0, wrap=0, dwell counter=0 and scan channel=0.
REQ-026 Reset asserted mid-operation SHALL abort immediately; the first edge after release SHALL behave as a normal IDLE evaluation.

Configuration
REQ-027 With MUX_SCAN_MASK_EN defined, the block SHALL add input port mask (NCH bits), where 1 means the channel is skipped in SCAN.
REQ-028 With the macro defined, scan advance and SCAN entry SHALL go to the next unmasked channel in ascending order, modulo NCH.
REQ-029 With the macro defined, wrap SHALL pulse when the advance passes index NCH-1.
REQ-030 With the macro defined and all channels masked in SCAN, y SHALL hold, valid SHALL be 0 and wrap SHALL be 0.
REQ-031 With the macro defined, MANUAL SHALL ignore mask.
REQ-032 Without MUX_SCAN_MASK_EN, the mask port SHALL not exist and all channels SHALL be scanned.

Structure
REQ-033 Package mux_scan_pkg SHALL hold the state enum type (IDLE, MANUAL, SCAN) and the default parameter constants.
REQ-034 Sub-module mux_scan_next SHALL be combinational and compute the next unmasked channel index plus the wrap flag; with the macro undefined it SHALL reduce to increment-modulo-NCH.

Verification
REQ-035 Reset check: rst_n=0 with en=1, mode=1 -> y=0, valid=0, ch=0, wrap=0 regardless of clk.
REQ-036 Manual check: NCH=4, W=8, d={8'hD3,8'hC2,8'hB1,8'hA0}, mode=0, sel=2 -> one cycle later y=8'hC2, ch=2, valid=1.
REQ-037 Scan check: NCH=4, DWELL=3, mode=1 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap=1 only on the cycle ch returns to 0.
REQ-038 Mid-dwell switch check: mode 1->0 at ch=2 with sel=1 -> next y=d[1]; mode back to 1 -> ch restarts at 0.
REQ-039 Disable check: en=0 while y=8'hB1 -> y holds 8'hB1, valid=0; NCH=3, sel=3 in MANUAL -> y=0, valid=0.
REQ-040 Mask check (macro defined): mask=4'b0101, DWELL=1 -> ch sequence 1,3,1,3 with wrap on each return to 1; mask=4'b1111 -> valid=0, y held.
